// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: state encoding, PC constants
// and the NOP encoding used by downstream flush logic.
package fetch_stage_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 16'h0000;
    localparam logic [ADDR_W-1:0]  PC_STEP_DEFAULT  = 16'd2;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 16'h0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetchState_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage and instruction memory.
interface fetch_stage_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 16
);
    logic                   imemReq;
    logic [ADDR_WIDTH-1:0]  imemAddr;
    logic                   imemReady;
    logic [INSTR_WIDTH-1:0] imemData;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemReady,
        input  imemData
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemReady,
        output imemData
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests instructions over the imem bus and
// feeds the IF/ID register, absorbing stalls and branch redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = ADDR_W,
    parameter int                     INSTR_WIDTH = INSTR_W,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0]  PC_STEP     = PC_STEP_DEFAULT
) (
    input  logic                   clk,
    input  logic                   flush,
    input  logic                   stall,
    input  logic                   branchTaken,
    input  logic [ADDR_WIDTH-1:0]  branchTarget,
    fetch_stage_if.master          imem,
    output logic [INSTR_WIDTH-1:0] instrOut,
    output logic [ADDR_WIDTH-1:0]  pcPlus2Out,
    output logic                   ifidWrite
);

    fetchState_t            state, stateNext;
    logic [ADDR_WIDTH-1:0]  pc, pcNext;
    logic [ADDR_WIDTH-1:0]  addrReg, addrNext;
    logic [INSTR_WIDTH-1:0] holdInstr, holdInstrNext;
    logic [ADDR_WIDTH-1:0]  holdPc, holdPcNext;

    logic                   reqComb;
    logic                   writeComb;
    logic [INSTR_WIDTH-1:0] instrComb;
    logic [ADDR_WIDTH-1:0]  pcPlusComb;
    logic [ADDR_WIDTH-1:0]  stepAddr;

    // Wraps modulo 2^ADDR_WIDTH by truncation.
    assign stepAddr = addrReg + PC_STEP;

    always_ff @(posedge clk or negedge flush) begin
        if (!flush) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            addrReg   <= RESET_PC;
            holdInstr <= '0;
            holdPc    <= '0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            addrReg   <= addrNext;
            holdInstr <= holdInstrNext;
            holdPc    <= holdPcNext;
        end
    end

    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        addrNext      = addrReg;
        holdInstrNext = holdInstr;
        holdPcNext    = holdPc;
        reqComb       = 1'b0;
        writeComb     = 1'b0;
        instrComb     = imem.imemData;
        pcPlusComb    = stepAddr;

        unique case (state)
            FETCH: begin
                reqComb = 1'b1;
                if (imem.imemReady) begin
                    if (branchTaken) begin
                        pcNext   = branchTarget;
                        addrNext = branchTarget;
                    end else if (stall) begin
                        holdInstrNext = imem.imemData;
                        holdPcNext    = stepAddr;
                        stateNext     = HOLD;
                    end else begin
                        writeComb = 1'b1;
                        pcNext    = stepAddr;
                        addrNext  = stepAddr;
                    end
                end else if (branchTaken) begin
                    // The outstanding request keeps its address; only the PC moves.
                    pcNext    = branchTarget;
                    stateNext = DISCARD;
                end
            end

            HOLD: begin
                instrComb  = holdInstr;
                pcPlusComb = holdPc;
                if (branchTaken) begin
                    pcNext    = branchTarget;
                    addrNext  = branchTarget;
                    stateNext = FETCH;
                end else if (!stall) begin
                    writeComb = 1'b1;
                    pcNext    = holdPc;
                    addrNext  = holdPc;
                    stateNext = FETCH;
                end
            end

            DISCARD: begin
                reqComb = 1'b1;
                if (imem.imemReady) begin
                    if (branchTaken) begin
                        pcNext   = branchTarget;
                        addrNext = branchTarget;
                    end else begin
                        addrNext = pc;
                    end
                    stateNext = FETCH;
                end else if (branchTaken) begin
                    pcNext = branchTarget;
                end
            end

            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    // Reset is level-sensitive here too so the outputs drop the moment flush falls.
    assign imem.imemReq  = flush & reqComb;
    assign imem.imemAddr = addrReg;
    assign ifidWrite     = flush & writeComb;
    assign instrOut      = flush ? instrComb  : '0;
    assign pcPlus2Out    = flush ? pcPlus2Comb() : '0;

    function automatic logic [ADDR_WIDTH-1:0] pcPlus2Comb();
        return pcPlusComb;
    endfunction

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: zero-wait flow, stall/hold,
// late-memory redirect, branch+stall collision, PC wrap and async reset.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk;
    logic        flush;
    logic        stall;
    logic        branchTaken;
    logic [15:0] branchTarget;
    logic [15:0] instrOut;
    logic [15:0] pcPlus2Out;
    logic        ifidWrite;

    int checks   = 0;
    int failures = 0;

    fetch_stage_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(16)) imemBus ();

    fetch_stage dut (
        .clk          (clk),
        .flush        (flush),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .imem         (imemBus.master),
        .instrOut     (instrOut),
        .pcPlus2Out   (pcPlus2Out),
        .ifidWrite    (ifidWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are checked 1ns later, well before the rising edge.
    task automatic applyStimulus(input logic st, input logic br, input logic [15:0] tgt,
                                 input logic rdy, input logic [15:0] dat);
        @(negedge clk);
        stall             = st;
        branchTaken       = br;
        branchTarget      = tgt;
        imemBus.imemReady = rdy;
        imemBus.imemData  = dat;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        flush             = 1'b0;
        stall             = 1'b0;
        branchTaken       = 1'b0;
        branchTarget      = 16'h0000;
        imemBus.imemReady = 1'b0;
        imemBus.imemData  = 16'h0000;
        #1;
        checkOutput("rst_req",   32'(imemBus.imemReq), 32'h0);
        checkOutput("rst_write", 32'(ifidWrite),       32'h0);
        checkOutput("rst_instr", 32'(instrOut),        32'h0);
        checkOutput("rst_pcp2",  32'(pcPlus2Out),      32'h0);

        repeat (2) @(negedge clk);
        flush = 1'b1;

        $display("[TB] zero-wait fetch");
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111);
        checkOutput("zw0_addr",  32'(imemBus.imemAddr), 32'h0000);
        checkOutput("zw0_req",   32'(imemBus.imemReq),  32'h1);
        checkOutput("zw0_write", 32'(ifidWrite),        32'h1);
        checkOutput("zw0_instr", 32'(instrOut),         32'h1111);
        checkOutput("zw0_pcp2",  32'(pcPlus2Out),       32'h0002);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222);
        checkOutput("zw1_addr",  32'(imemBus.imemAddr), 32'h0002);
        checkOutput("zw1_write", 32'(ifidWrite),        32'h1);
        checkOutput("zw1_pcp2",  32'(pcPlus2Out),       32'h0004);

        $display("[TB] stall and hold");
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 16'hA5A5);
        checkOutput("st0_addr",  32'(imemBus.imemAddr), 32'h0004);
        checkOutput("st0_write", 32'(ifidWrite),        32'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 16'hDEAD);
            checkOutput("hold_req",   32'(imemBus.imemReq), 32'h0);
            checkOutput("hold_write", 32'(ifidWrite),       32'h0);
            checkOutput("hold_instr", 32'(instrOut),        32'hA5A5);
            checkOutput("hold_pcp2",  32'(pcPlus2Out),      32'h0006);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'hDEAD);
        checkOutput("rel_write", 32'(ifidWrite),  32'h1);
        checkOutput("rel_instr", 32'(instrOut),   32'hA5A5);
        checkOutput("rel_pcp2",  32'(pcPlus2Out), 32'h0006);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("post_addr",  32'(imemBus.imemAddr), 32'h0006);
        checkOutput("post_req",   32'(imemBus.imemReq),  32'h1);
        checkOutput("post_write", 32'(ifidWrite),        32'h0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333);
        checkOutput("f6_write", 32'(ifidWrite),  32'h1);
        checkOutput("f6_pcp2",  32'(pcPlus2Out), 32'h0008);

        $display("[TB] redirect with late memory");
        applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000);
        checkOutput("rd0_addr",  32'(imemBus.imemAddr), 32'h0008);
        checkOutput("rd0_write", 32'(ifidWrite),        32'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
            checkOutput("disc_addr", 32'(imemBus.imemAddr), 32'h0008);
            checkOutput("disc_req",  32'(imemBus.imemReq),  32'h1);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'hBAD0);
        checkOutput("disc_rdy_addr",  32'(imemBus.imemAddr), 32'h0008);
        checkOutput("disc_rdy_write", 32'(ifidWrite),        32'h0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444);
        checkOutput("tgt_addr",  32'(imemBus.imemAddr), 32'h0100);
        checkOutput("tgt_write", 32'(ifidWrite),        32'h1);
        checkOutput("tgt_pcp2",  32'(pcPlus2Out),       32'h0102);

        $display("[TB] branch beats stall");
        applyStimulus(1'b1, 1'b1, 16'h0200, 1'b1, 16'h5555);
        checkOutput("bs_addr",  32'(imemBus.imemAddr), 32'h0102);
        checkOutput("bs_write", 32'(ifidWrite),        32'h0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("bs_next_req",  32'(imemBus.imemReq),  32'h1);
        checkOutput("bs_next_addr", 32'(imemBus.imemAddr), 32'h0200);

        $display("[TB] PC wrap");
        applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h0BAD);
        checkOutput("wr_br_write", 32'(ifidWrite), 32'h0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h6666);
        checkOutput("wr0_addr",  32'(imemBus.imemAddr), 32'hFFFE);
        checkOutput("wr0_write", 32'(ifidWrite),        32'h1);
        checkOutput("wr0_pcp2",  32'(pcPlus2Out),       32'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777);
        checkOutput("wr1_addr",  32'(imemBus.imemAddr), 32'h0000);
        checkOutput("wr1_instr", 32'(instrOut),         32'h7777);
        checkOutput("wr1_pcp2",  32'(pcPlus2Out),       32'h0002);

        $display("[TB] async reset during discard");
        applyStimulus(1'b0, 1'b1, 16'h0300, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("ar_disc_req",  32'(imemBus.imemReq),  32'h1);
        checkOutput("ar_disc_addr", 32'(imemBus.imemAddr), 32'h0002);
        #1 flush = 1'b0;
        #1;
        checkOutput("ar_req",   32'(imemBus.imemReq), 32'h0);
        checkOutput("ar_write", 32'(ifidWrite),       32'h0);
        checkOutput("ar_instr", 32'(instrOut),        32'h0);
        @(negedge clk);
        flush = 1'b1;
        #1;
        checkOutput("ar_post_req",  32'(imemBus.imemReq),  32'h1);
        checkOutput("ar_post_addr", 32'(imemBus.imemAddr), 32'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h8888);
        checkOutput("ar_fetch_write", 32'(ifidWrite),  32'h1);
        checkOutput("ar_fetch_pcp2",  32'(pcPlus2Out), 32'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
